// File: rtl/input_unit_pkg.sv
// rtl/input_unit_pkg.sv - shared flit layout, direction encodings and route computation
// ROUTE_TORUS_EN selects minimal wrap-around routing; undefined gives mesh dimension-order routing.
package input_unit_pkg;

  localparam int FLIT_SIZE = 32;
  localparam int VC_NUM    = 4;
  localparam int ROUTE_LEN = 3;
  localparam int COORD_W   = 2;

  localparam int X_SIZE = 4;
  localparam int Y_SIZE = 4;
  localparam int Z_SIZE = 4;

  localparam int FLIT_VC_LSB    = 0;
  localparam int FLIT_VC_W      = 2;
  localparam int FLIT_DST_X_LSB = 2;
  localparam int FLIT_DST_Y_LSB = 4;
  localparam int FLIT_DST_Z_LSB = 6;
  localparam int FLIT_DST_W     = COORD_W;

  typedef enum logic [ROUTE_LEN-1:0] {
    DIR_LOCAL = 3'd0,
    DIR_XPOS  = 3'd1,
    DIR_XNEG  = 3'd2,
    DIR_YPOS  = 3'd3,
    DIR_YNEG  = 3'd4,
    DIR_ZPOS  = 3'd5,
    DIR_ZNEG  = 3'd6
  } dir_e;

`ifdef ROUTE_TORUS_EN
  // Forward distance on the ring; going positive wins when both ways are equally long.
  function automatic dir_e dim_dir(input logic [COORD_W-1:0] dst, input logic [COORD_W-1:0] loc,
                                   input int size, input dir_e pos, input dir_e neg);
    int d;
    d = (int'(dst) - int'(loc) + size) % size;
    if (d == 0)
      return DIR_LOCAL;
    else if (2 * d <= size)
      return pos;
    else
      return neg;
  endfunction
`else
  function automatic dir_e dim_dir(input logic [COORD_W-1:0] dst, input logic [COORD_W-1:0] loc,
                                   input dir_e pos, input dir_e neg);
    if (dst > loc)
      return pos;
    else if (dst < loc)
      return neg;
    else
      return DIR_LOCAL;
  endfunction
`endif

  function automatic dir_e compute_route(
    input logic [COORD_W-1:0] dx, input logic [COORD_W-1:0] dy, input logic [COORD_W-1:0] dz,
    input logic [COORD_W-1:0] lx, input logic [COORD_W-1:0] ly, input logic [COORD_W-1:0] lz);
    dir_e r;
`ifdef ROUTE_TORUS_EN
    r = dim_dir(dx, lx, X_SIZE, DIR_XPOS, DIR_XNEG);
    if (r == DIR_LOCAL) r = dim_dir(dy, ly, Y_SIZE, DIR_YPOS, DIR_YNEG);
    if (r == DIR_LOCAL) r = dim_dir(dz, lz, Z_SIZE, DIR_ZPOS, DIR_ZNEG);
`else
    r = dim_dir(dx, lx, DIR_XPOS, DIR_XNEG);
    if (r == DIR_LOCAL) r = dim_dir(dy, ly, DIR_YPOS, DIR_YNEG);
    if (r == DIR_LOCAL) r = dim_dir(dz, lz, DIR_ZPOS, DIR_ZNEG);
`endif
    return r;
  endfunction

endpackage

// File: rtl/input_unit_vc_fifo.sv
// rtl/input_unit_vc_fifo.sv - per-VC circular buffer holding flit plus precomputed route
module vc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign valid_o     = (count_q != '0);
  assign data_o      = mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && valid_o;
  assign count_nxt_o = count_d;

  // Depth is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/input_unit.sv
// rtl/input_unit.sv - router input port: route computation and per-VC buffering
// Routing mode follows ROUTE_TORUS_EN (see input_unit_pkg).
module input_unit #(
  parameter int VC_NUM    = input_unit_pkg::VC_NUM,
  parameter int BUF_DEPTH = 4,
  parameter int LOC_X     = 0,
  parameter int LOC_Y     = 0,
  parameter int LOC_Z     = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [input_unit_pkg::FLIT_SIZE-1:0]          in,
  input  logic                                          in_valid,
  output logic [VC_NUM-1:0]                             in_avail,
  output logic [VC_NUM*input_unit_pkg::FLIT_SIZE-1:0]   out,
  output logic [VC_NUM*input_unit_pkg::ROUTE_LEN-1:0]   route_out,
  output logic [VC_NUM-1:0]                             out_valid,
  input  logic [VC_NUM-1:0]                             out_avail,
  output logic                                          overflow_err
);

  import input_unit_pkg::*;

  localparam int ENTRY_W = FLIT_SIZE + ROUTE_LEN;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;

  logic [FLIT_VC_W-1:0] vc_sel;
  logic [ROUTE_LEN-1:0] route_in;
  logic [ENTRY_W-1:0]   entry_in;
  logic [VC_NUM-1:0]    in_avail_q, in_avail_d;
  logic [VC_NUM-1:0]    push, pop, full, ovf_hit;
  logic                 overflow_q, overflow_d;

  assign vc_sel   = in[FLIT_VC_LSB +: FLIT_VC_W];
  assign route_in = compute_route(in[FLIT_DST_X_LSB +: FLIT_DST_W],
                                  in[FLIT_DST_Y_LSB +: FLIT_DST_W],
                                  in[FLIT_DST_Z_LSB +: FLIT_DST_W],
                                  COORD_W'(LOC_X), COORD_W'(LOC_Y), COORD_W'(LOC_Z));
  assign entry_in = {in, route_in};

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count_nxt;
    logic               hit;

    assign hit        = in_valid && (vc_sel == FLIT_VC_W'(v));
    assign push[v]    = hit && in_avail_q[v];
    assign ovf_hit[v] = hit && full[v];
    assign pop[v]     = out_valid[v] && out_avail[v];
    // Registered from the next count so a same-cycle pop cannot open the slot early.
    assign in_avail_d[v] = (count_nxt < CNT_W'(BUF_DEPTH));

    vc_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (ENTRY_W)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[v]),
      .data_i      (entry_in),
      .pop_i       (pop[v]),
      .data_o      (head),
      .valid_o     (out_valid[v]),
      .full_o      (full[v]),
      .count_nxt_o (count_nxt)
    );

    assign out[v*FLIT_SIZE +: FLIT_SIZE]       = head[ENTRY_W-1 -: FLIT_SIZE];
    assign route_out[v*ROUTE_LEN +: ROUTE_LEN] = head[ROUTE_LEN-1:0];
  end

  assign overflow_d   = overflow_q || (|ovf_hit);
  assign in_avail     = in_avail_q;
  assign overflow_err = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_avail_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_avail_q <= in_avail_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_input_unit.sv
// tb/tb_input_unit.sv - scoreboard bench for input_unit (mesh or ROUTE_TORUS_EN build)
module tb_input_unit;
  import input_unit_pkg::*;

  localparam int VCN   = VC_NUM;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [FLIT_SIZE-1:0]     in_flit;
  logic                     in_valid;
  logic [VCN-1:0]           in_avail, t_in_avail;
  logic [VCN*FLIT_SIZE-1:0] out_bus, t_out_bus;
  logic [VCN*ROUTE_LEN-1:0] route_bus, t_route_bus;
  logic [VCN-1:0]           out_valid, t_out_valid;
  logic [VCN-1:0]           out_avail;
  logic                     overflow_err, t_overflow_err;

  typedef struct {
    int                   vc;
    logic [FLIT_SIZE-1:0] flit;
    logic [ROUTE_LEN-1:0] route;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  input_unit #(.VC_NUM(VCN), .BUF_DEPTH(DEPTH), .LOC_X(1), .LOC_Y(1), .LOC_Z(1)) u_dut (
    .clk(clk), .rst(rst), .in(in_flit), .in_valid(in_valid), .in_avail(in_avail),
    .out(out_bus), .route_out(route_bus), .out_valid(out_valid), .out_avail(out_avail),
    .overflow_err(overflow_err)
  );

  // Origin router, used only to observe the wrap-around route choice.
  input_unit #(.VC_NUM(VCN), .BUF_DEPTH(DEPTH), .LOC_X(0), .LOC_Y(0), .LOC_Z(0)) u_dut_t (
    .clk(clk), .rst(rst), .in(in_flit), .in_valid(in_valid), .in_avail(t_in_avail),
    .out(t_out_bus), .route_out(t_route_bus), .out_valid(t_out_valid), .out_avail(out_avail),
    .overflow_err(t_overflow_err)
  );

  function automatic logic [FLIT_SIZE-1:0] mk(int vc, int x, int y, int z, int pl);
    logic [FLIT_SIZE-1:0] f;
    f = '0;
    f[FLIT_VC_LSB +: FLIT_VC_W]     = FLIT_VC_W'(vc);
    f[FLIT_DST_X_LSB +: FLIT_DST_W] = FLIT_DST_W'(x);
    f[FLIT_DST_Y_LSB +: FLIT_DST_W] = FLIT_DST_W'(y);
    f[FLIT_DST_Z_LSB +: FLIT_DST_W] = FLIT_DST_W'(z);
    f[FLIT_SIZE-1:8]                = 24'(pl);
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int vc, input int x, input int y, input int z, input int pl,
                      input logic [ROUTE_LEN-1:0] route, input bit expect_out);
    exp_t e;
    in_flit  = mk(vc, x, y, z, pl);
    in_valid = 1'b1;
    if (expect_out) begin
      e.vc = vc; e.flit = in_flit; e.route = route;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush_vc(input int vc);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].vc == vc) sb.delete(i);
  endtask

  // Monitor: a head that will be popped at the next edge must match the oldest expected flit of its VC.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int v = 0; v < VCN; v++) begin
        if (out_valid[v] && out_avail[v]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].vc == v) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop vc=%0d actual=%0h required=none", v,
                     out_bus[v*FLIT_SIZE +: FLIT_SIZE]);
          end else begin
            check($sformatf("flit_vc%0d", v), 32'(out_bus[v*FLIT_SIZE +: FLIT_SIZE]), 32'(sb[idx].flit));
            check($sformatf("route_vc%0d", v), 32'(route_bus[v*ROUTE_LEN +: ROUTE_LEN]), 32'(sb[idx].route));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_flit   = '0;
    out_avail = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_avail", 32'(in_avail), 32'h0);
    check("rst_overflow", 32'(overflow_err), 32'h0);
    rst = 1'b1;
    tick();
    check("post_rst_in_avail", 32'(in_avail), 32'hF);

    // Mesh route and one-cycle latency; origin router checks the wrap choice for dst_x=3.
    send(0, 3, 1, 0, 'h11, DIR_XPOS, 1'b1);
    check("lat_out_valid0", 32'(out_valid[0]), 32'h1);
    check("lat_route0", 32'(route_bus[0 +: ROUTE_LEN]), 32'(DIR_XPOS));
`ifdef ROUTE_TORUS_EN
    check("wrap_route_xneg", 32'(t_route_bus[0 +: ROUTE_LEN]), 32'(DIR_XNEG));
`else
    check("wrap_route_xpos", 32'(t_route_bus[0 +: ROUTE_LEN]), 32'(DIR_XPOS));
`endif
    out_avail[0] = 1'b1;
    send(0, 1, 1, 1, 'h12, DIR_LOCAL, 1'b1);
    send(0, 1, 0, 1, 'h13, DIR_YNEG, 1'b1);
    send(0, 1, 1, 3, 'h14, DIR_ZPOS, 1'b1);
    send(0, 0, 2, 2, 'h15, DIR_XNEG, 1'b1);
    repeat (3) tick();
    check("drain_vc0", 32'(out_valid[0]), 32'h0);
    out_avail = '0;

    send(0, 0, 0, 0, 'h16, DIR_XNEG, 1'b1);
    check("origin_local", 32'(t_route_bus[0 +: ROUTE_LEN]), 32'(DIR_LOCAL));
    out_avail[0] = 1'b1;
    tick();
    out_avail = '0;

    // Fill VC1 to depth, then drain in order.
    for (int i = 0; i < 4; i++) send(1, 1, 2, 1, 'h21 + i, DIR_YPOS, 1'b1);
    check("fill_in_avail1", 32'(in_avail[1]), 32'h0);
    check("fill_in_avail0", 32'(in_avail[0]), 32'h1);
    out_avail[1] = 1'b1;
    repeat (4) tick();
    out_avail = '0;
    check("fill_drained", 32'(out_valid[1]), 32'h0);

    // Push and pop together on VC2 keeps two entries.
    send(2, 2, 1, 1, 'h31, DIR_XPOS, 1'b1);
    send(2, 2, 1, 1, 'h32, DIR_XPOS, 1'b1);
    out_avail[2] = 1'b1;
    send(2, 2, 1, 1, 'h33, DIR_XPOS, 1'b1);
    out_avail = '0;
    check("simul_in_avail2", 32'(in_avail[2]), 32'h1);
    check("simul_valid2", 32'(out_valid[2]), 32'h1);
    out_avail[2] = 1'b1;
    repeat (2) tick();
    out_avail = '0;
    check("simul_count2", 32'(out_valid[2]), 32'h0);

    // Overflow on VC3: fifth flit dropped, error sticky.
    for (int i = 0; i < 4; i++) send(3, 1, 1, 0, 'h41 + i, DIR_ZNEG, 1'b1);
    check("ovf_in_avail3", 32'(in_avail[3]), 32'h0);
    check("ovf_before", 32'(overflow_err), 32'h0);
    send(3, 1, 1, 0, 'h45, DIR_ZNEG, 1'b0);
    check("ovf_set", 32'(overflow_err), 32'h1);
    check("ovf_other_vc", 32'(in_avail[0]), 32'h1);
    out_avail[3] = 1'b1;
    repeat (4) tick();
    out_avail = '0;
    check("ovf_dropped", 32'(out_valid[3]), 32'h0);
    check("ovf_sticky", 32'(overflow_err), 32'h1);

    // Reset with three flits buffered.
    for (int i = 0; i < 3; i++) send(0, 2, 1, 1, 'h51 + i, DIR_XPOS, 1'b1);
    check("pre_rst_valid0", 32'(out_valid[0]), 32'h1);
    rst = 1'b0;
    tick();
    flush_vc(0);
    check("mid_rst_out_valid", 32'(out_valid), 32'h0);
    check("mid_rst_overflow", 32'(overflow_err), 32'h0);
    check("mid_rst_in_avail", 32'(in_avail), 32'h0);
    rst = 1'b1;
    tick();
    check("after_rst_in_avail", 32'(in_avail), 32'hF);
    check("after_rst_out_valid", 32'(out_valid), 32'h0);

    tick();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
